lnrv_exu_flush_ctrl: RTL and testbench

Pipeline flush responder for the lnrv EXU. It arbitrates flush requests from the exception unit, the system-return path (mret/dret) and the branch unit, and acknowledges exactly one per acceptance. It registers the redirect target (op1 + op2) and holds a flush request toward the IFU until the IFU accepts it. It also drives the squash signal for younger instructions in IDU/EXU and counts completed flushes.

---
 rtl/lnrv_exu_flush_ctrl.sv | 126 ++++++++++++
 tb/tb_lnrv_exu_flush_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lnrv_exu_flush_ctrl.sv
// -----------------------------------------------------------------------------
// lnrv_exu_flush_ctrl
//
// Pipeline flush responder for the lnrv EXU. Three flush sources compete for
// a single redirect slot toward the IFU with fixed priority
// exception > system return (mret/dret) > branch unit. The winner is
// acknowledged in the same cycle, its target (op1 + op2) is registered and
// presented to the IFU as a held request until the IFU acknowledges it.
//
// Ports:
//   clk, reset_n                   core clock, async active-low reset
//   excp_flush_req/ack/pc_op1/op2  exception unit flush handshake + operands
//   sys_flush_req/ack/pc_op1/op2   mret/dret redirect handshake + operands
//   bru_flush_req/ack/pc_op1/op2   branch mispredict handshake + operands
//   ifu_flush_req/ack/pc           registered redirect toward the IFU
//   pipe_kill                      squash younger instructions in IDU/EXU
//   flush_cnt                      count of IFU-accepted flushes (wraps)
// -----------------------------------------------------------------------------
module lnrv_exu_flush_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic                 excp_flush_req,
  output logic                 excp_flush_ack,
  input  logic [XLEN-1:0]      excp_flush_pc_op1,
  input  logic [XLEN-1:0]      excp_flush_pc_op2,

  input  logic                 sys_flush_req,
  output logic                 sys_flush_ack,
  input  logic [XLEN-1:0]      sys_flush_pc_op1,
  input  logic [XLEN-1:0]      sys_flush_pc_op2,

  input  logic                 bru_flush_req,
  output logic                 bru_flush_ack,
  input  logic [XLEN-1:0]      bru_flush_pc_op1,
  input  logic [XLEN-1:0]      bru_flush_pc_op2,

  output logic                 ifu_flush_req,
  input  logic                 ifu_flush_ack,
  output logic [XLEN-1:0]      ifu_flush_pc,

  output logic                 pipe_kill,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      target_q, target_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 acc_en;
  logic                 any_req;
  logic                 ifu_done;
  logic [XLEN-1:0]      win_op1;
  logic [XLEN-1:0]      win_op2;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    win_op1  = '0;
    win_op2  = '0;

    // The IFU handing back the current redirect frees the slot in the same
    // cycle, which is what allows one flush per cycle sustained.
    ifu_done = (state_q == REQ) & ifu_flush_ack;
    acc_en   = (state_q == IDLE) | ifu_done;
    any_req  = excp_flush_req | sys_flush_req | bru_flush_req;

    excp_flush_ack = acc_en & excp_flush_req;
    sys_flush_ack  = acc_en & sys_flush_req & ~excp_flush_req;
    bru_flush_ack  = acc_en & bru_flush_req & ~excp_flush_req & ~sys_flush_req;

    if (excp_flush_req) begin
      win_op1 = excp_flush_pc_op1;
      win_op2 = excp_flush_pc_op2;
    end else if (sys_flush_req) begin
      win_op1 = sys_flush_pc_op1;
      win_op2 = sys_flush_pc_op2;
    end else begin
      win_op1 = bru_flush_pc_op1;
      win_op2 = bru_flush_pc_op2;
    end

    if (acc_en & any_req) begin
      // Carry out of the adder is dropped on purpose: the target wraps.
      target_d = win_op1 + win_op2;
      state_d  = REQ;
    end else if (ifu_done) begin
      state_d  = IDLE;
    end

    if (ifu_done) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    ifu_flush_req = (state_q == REQ);
    ifu_flush_pc  = target_q;
    pipe_kill     = (acc_en & any_req) | (state_q == REQ);
    flush_cnt     = cnt_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lnrv_exu_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lnrv_exu_flush_ctrl
//
// Directed vector table for the documented scenarios, a hand-written
// mid-redirect reset sequence, then constrained-random traffic compared to a
// transaction-level model of the flush slot. A second instance built with a
// 4-bit counter shares all inputs so counter wrap-around is exercised.
// -----------------------------------------------------------------------------
module tb_lnrv_exu_flush_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;

  // Requesters indexed by priority: 0 = excp, 1 = sys, 2 = bru.
  logic            req_v [3];
  logic [XLEN-1:0] op1_v [3];
  logic [XLEN-1:0] op2_v [3];
  logic            ifu_ack;

  logic            excp_ack, sys_ack, bru_ack;
  logic            ifu_req;
  logic [XLEN-1:0] ifu_pc;
  logic            kill;
  logic [31:0]     cnt;

  logic            excp_ack4, sys_ack4, bru_ack4, ifu_req4, kill4;
  logic [XLEN-1:0] ifu_pc4;
  logic [3:0]      cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lnrv_exu_flush_ctrl #(.XLEN(XLEN), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .excp_flush_req(req_v[0]), .excp_flush_ack(excp_ack),
    .excp_flush_pc_op1(op1_v[0]), .excp_flush_pc_op2(op2_v[0]),
    .sys_flush_req(req_v[1]), .sys_flush_ack(sys_ack),
    .sys_flush_pc_op1(op1_v[1]), .sys_flush_pc_op2(op2_v[1]),
    .bru_flush_req(req_v[2]), .bru_flush_ack(bru_ack),
    .bru_flush_pc_op1(op1_v[2]), .bru_flush_pc_op2(op2_v[2]),
    .ifu_flush_req(ifu_req), .ifu_flush_ack(ifu_ack), .ifu_flush_pc(ifu_pc),
    .pipe_kill(kill), .flush_cnt(cnt)
  );

  lnrv_exu_flush_ctrl #(.XLEN(XLEN), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .excp_flush_req(req_v[0]), .excp_flush_ack(excp_ack4),
    .excp_flush_pc_op1(op1_v[0]), .excp_flush_pc_op2(op2_v[0]),
    .sys_flush_req(req_v[1]), .sys_flush_ack(sys_ack4),
    .sys_flush_pc_op1(op1_v[1]), .sys_flush_pc_op2(op2_v[1]),
    .bru_flush_req(req_v[2]), .bru_flush_ack(bru_ack4),
    .bru_flush_pc_op1(op1_v[2]), .bru_flush_pc_op2(op2_v[2]),
    .ifu_flush_req(ifu_req4), .ifu_flush_ack(ifu_ack), .ifu_flush_pc(ifu_pc4),
    .pipe_kill(kill4), .flush_cnt(cnt4)
  );

  // ---------------------------------------------------------------------------
  // Reference model: one redirect slot, a pending flag, a target, a counter.
  // ---------------------------------------------------------------------------
  bit              m_pending;
  logic [XLEN-1:0] m_target;
  logic [31:0]     m_cnt;
  bit              m_can_acc;
  int              m_win;
  bit              m_ack [3];

  task automatic model_reset();
    m_pending = 0;
    m_target  = '0;
    m_cnt     = '0;
  endtask

  task automatic model_eval();
    m_can_acc = !m_pending || (ifu_ack === 1'b1);
    m_win     = -1;
    for (int i = 0; i < 3; i++)
      if (req_v[i] && m_win < 0) m_win = i;
    for (int i = 0; i < 3; i++)
      m_ack[i] = m_can_acc && (m_win == i);
  endtask

  task automatic model_commit();
    if (m_pending && ifu_ack) m_cnt = m_cnt + 1;
    if (m_can_acc && m_win >= 0) begin
      m_target  = op1_v[m_win] + op2_v[m_win];
      m_pending = 1;
    end else if (ifu_ack) begin
      m_pending = 0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0]      req;      // {excp, sys, bru}
    logic [XLEN-1:0] e1, e2, s1, s2, b1, b2;
    logic            ifu_ack;
    logic [2:0]      acks;     // {excp, sys, bru}
    logic            ifu_req;
    logic [XLEN-1:0] pc;
    logic            kill;
    logic [31:0]     cnt;
  } vec_t;

  localparam int NVEC = 23;
  vec_t tbl [NVEC];

  function automatic vec_t mk(logic [2:0] req, logic [XLEN-1:0] e1, e2, s1, s2,
                              b1, b2, logic ia, logic [2:0] acks, logic ireq,
                              logic [XLEN-1:0] pc, logic kl, logic [31:0] cn);
    vec_t v;
    v.req = req; v.e1 = e1; v.e2 = e2; v.s1 = s1; v.s2 = s2; v.b1 = b1;
    v.b2 = b2; v.ifu_ack = ia; v.acks = acks; v.ifu_req = ireq; v.pc = pc;
    v.kill = kl; v.cnt = cn;
    return v;
  endfunction

  // One clock: check at the falling edge, advance the model at the rising
  // edge, then return just after it so callers may drive the next inputs.
  task automatic cycle(input bit has_vec, input vec_t v, input int idx);
    @(negedge clk);
    model_eval();
    check("excp_ack",  64'(excp_ack), 64'(m_ack[0]));
    check("sys_ack",   64'(sys_ack),  64'(m_ack[1]));
    check("bru_ack",   64'(bru_ack),  64'(m_ack[2]));
    check("ifu_req",   64'(ifu_req),  64'(m_pending));
    check("ifu_pc",    64'(ifu_pc),   64'(m_target));
    check("pipe_kill", 64'(kill),     64'((m_can_acc && m_win >= 0) || m_pending));
    check("flush_cnt", 64'(cnt),      64'(m_cnt));
    check("flush_cnt4", 64'(cnt4),    64'(m_cnt[3:0]));
    if (has_vec) begin
      check($sformatf("vec%0d_acks", idx), 64'({excp_ack, sys_ack, bru_ack}),
            64'(v.acks));
      check($sformatf("vec%0d_ifu_req", idx), 64'(ifu_req), 64'(v.ifu_req));
      check($sformatf("vec%0d_ifu_pc", idx), 64'(ifu_pc), 64'(v.pc));
      check($sformatf("vec%0d_kill", idx), 64'(kill), 64'(v.kill));
      check($sformatf("vec%0d_cnt", idx), 64'(cnt), 64'(v.cnt));
    end
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drive_idle();
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b0;
      op1_v[i] = '0;
      op2_v[i] = '0;
    end
    ifu_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ifu_req"}, 64'(ifu_req), 64'(0));
    check({tag, "_pipe_kill"}, 64'(kill), 64'(0));
    check({tag, "_ifu_pc"}, 64'(ifu_pc), 64'(0));
    check({tag, "_flush_cnt"}, 64'(cnt), 64'(0));
    check({tag, "_acks"}, 64'({excp_ack, sys_ack, bru_ack}), 64'(0));
  endtask

  vec_t nv;

  initial begin
    tbl[0]  = mk(3'b100, 'h800, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 1, 0);
    tbl[1]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 'h800, 1, 0);
    tbl[2]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 'h800, 1, 0);
    tbl[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 3'b000, 1, 'h800, 1, 0);
    tbl[4]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 'h800, 0, 1);
    tbl[5]  = mk(3'b111, 'h1000, 0, 'h2000, 4, 'h3000, 8, 0, 3'b100, 0, 'h800, 1, 1);
    tbl[6]  = mk(3'b011, 0, 0, 'h2000, 4, 'h3000, 8, 1, 3'b010, 1, 'h1000, 1, 1);
    tbl[7]  = mk(3'b001, 0, 0, 0, 0, 'h3000, 8, 1, 3'b001, 1, 'h2004, 1, 2);
    tbl[8]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 3'b000, 1, 'h3008, 1, 3);
    tbl[9]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 'h3008, 0, 4);
    tbl[10] = mk(3'b001, 0, 0, 0, 0, 'h8000_0000, 'h10, 0, 3'b001, 0, 'h3008, 1, 4);
    tbl[11] = mk(3'b010, 0, 0, 'h100, 4, 0, 0, 1, 3'b010, 1, 'h8000_0010, 1, 4);
    tbl[12] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 'h104, 1, 5);
    tbl[13] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 3'b000, 1, 'h104, 1, 5);
    tbl[14] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 'h104, 0, 6);
    tbl[15] = mk(3'b100, 'hFFFF_FFFC, 8, 0, 0, 0, 0, 1, 3'b100, 0, 'h104, 1, 6);
    tbl[16] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 3'b000, 1, 'h4, 1, 6);
    tbl[17] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 'h4, 0, 7);
    tbl[18] = mk(3'b001, 0, 0, 0, 0, 'h40, 0, 0, 3'b001, 0, 'h4, 1, 7);
    tbl[19] = mk(3'b100, 'h200, 'h20, 0, 0, 0, 0, 0, 3'b000, 1, 'h40, 1, 7);
    tbl[20] = mk(3'b100, 'h200, 'h20, 0, 0, 0, 0, 0, 3'b000, 1, 'h40, 1, 7);
    tbl[21] = mk(3'b100, 'h200, 'h20, 0, 0, 0, 0, 1, 3'b100, 1, 'h40, 1, 7);
    tbl[22] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 'h220, 1, 8);
    nv = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);

    // Power-on reset
    drive_idle();
    reset_n = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed scenarios
    for (int k = 0; k < NVEC; k++) begin
      req_v[0] = tbl[k].req[2]; op1_v[0] = tbl[k].e1; op2_v[0] = tbl[k].e2;
      req_v[1] = tbl[k].req[1]; op1_v[1] = tbl[k].s1; op2_v[1] = tbl[k].s2;
      req_v[2] = tbl[k].req[0]; op1_v[2] = tbl[k].b1; op2_v[2] = tbl[k].b2;
      ifu_ack  = tbl[k].ifu_ack;
      cycle(1'b1, tbl[k], k);
    end

    // Reset while a redirect is pending: dropped immediately, not counted.
    drive_idle();
    check("mid_pending_before_rst", 64'(ifu_req), 64'(1));
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    check("mid_rst_cnt4", 64'(cnt4), 64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    ifu_ack = 1'b1;          // ignored in IDLE
    cycle(1'b0, nv, 0);
    ifu_ack = 1'b0;
    cycle(1'b0, nv, 0);
    check("post_rst_cnt", 64'(cnt), 64'(0));

    // Random traffic obeying the hold-until-acked protocol.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_v[i] && ($urandom_range(0, 2) == 0)) begin
          req_v[i] = 1'b1;
          op1_v[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                                 : $urandom;
          op2_v[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
        end
      end
      ifu_ack = 1'($urandom_range(0, 1));
      cycle(1'b0, nv, 0);
      for (int i = 0; i < 3; i++)
        if (m_ack[i]) req_v[i] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
